// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor: statistics and state tracker for a 2-bit magnitude
// comparator's gt/eq/lt result flags. Keeps saturating per-result counters,
// an equality streak with a lock indication, and the last accepted result.
// Optional build macro: CMP_MON_ONEHOT_CHECK_EN. When it is defined,
// malformed (not one-hot) samples are rejected and raise a sticky err.
// Without it, err is tied low and multi-flag samples resolve eq > gt > lt.
module cmp_result_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] streak,
    output logic             lock,
    output logic [1:0]       state,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EQ   = 2'd1,
        ST_GT   = 2'd2,
        ST_LT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LOCK_TH = CNT_W'(LOCK_N);

    state_t           state_q;
    logic             accept;
    logic             sel_eq;
    logic             sel_gt;
    logic             sel_lt;
    logic [CNT_W-1:0] streak_nxt;

`ifdef CMP_MON_ONEHOT_CHECK_EN
    logic [1:0] flag_cnt;
    logic       malformed;

    // Only strictly one-hot samples are accepted; anything else is malformed.
    always_comb begin
        flag_cnt  = 2'(gt) + 2'(eq) + 2'(lt);
        accept    = in_valid && (flag_cnt == 2'd1);
        malformed = in_valid && (flag_cnt != 2'd1);
        sel_eq    = eq;
        sel_gt    = gt;
        sel_lt    = lt;
    end

    // Sticky malformed-sample flag, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (malformed) begin
            err <= 1'b1;
        end
    end
`else
    // Any set flag is accepted; overlapping flags resolve eq > gt > lt.
    always_comb begin
        accept = in_valid && (gt || eq || lt);
        sel_eq = eq;
        sel_gt = !eq && gt;
        sel_lt = !eq && !gt && lt;
    end

    assign err = 1'b0;
`endif

    // Next streak value; lock is derived from it so both move together.
    always_comb begin
        streak_nxt = streak;
        if (accept) begin
            if (sel_eq) begin
                streak_nxt = (streak == CNT_MAX) ? streak : streak + CNT_W'(1);
            end else begin
                streak_nxt = '0;
            end
        end
    end

    // Result state machine, saturating counters, streak and lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gt_cnt  <= '0;
            eq_cnt  <= '0;
            lt_cnt  <= '0;
            streak  <= '0;
            lock    <= 1'b0;
        end else if (clr) begin
            state_q <= ST_IDLE;
            gt_cnt  <= '0;
            eq_cnt  <= '0;
            lt_cnt  <= '0;
            streak  <= '0;
            lock    <= 1'b0;
        end else if (accept) begin
            if (sel_eq) begin
                state_q <= ST_EQ;
                if (eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + CNT_W'(1);
            end else if (sel_gt) begin
                state_q <= ST_GT;
                if (gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + CNT_W'(1);
            end else if (sel_lt) begin
                state_q <= ST_LT;
                if (lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + CNT_W'(1);
            end
            streak <= streak_nxt;
            lock   <= (streak_nxt >= LOCK_TH);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Testbench for cmp_result_monitor: directed vectors, a behavioural model
// checked every cycle, and literal expectations at key points.
module tb_cmp_result_monitor;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LOCK_N = 4;
    localparam int          MAXV   = 255;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic             gt       = 1'b0;
    logic             eq       = 1'b0;
    logic             lt       = 1'b0;
    logic             clr      = 1'b0;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] streak;
    logic             lock;
    logic [1:0]       state;
    logic             err;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model state: plain integers, state as 0 idle / 1 eq / 2 gt / 3 lt.
    int m_gt = 0, m_eq = 0, m_lt = 0, m_streak = 0, m_state = 0, m_err = 0;

    always #5 clk = ~clk;

    cmp_result_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .gt(gt), .eq(eq), .lt(lt), .clr(clr),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
        .streak(streak), .lock(lock), .state(state), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_gt = 0; m_eq = 0; m_lt = 0; m_streak = 0; m_state = 0; m_err = 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= MAXV) ? MAXV : v + 1;
    endfunction

    function automatic void model_take(input int kind);
        case (kind)
            1: begin m_eq = sat_inc(m_eq); m_streak = sat_inc(m_streak); end
            2: begin m_gt = sat_inc(m_gt); m_streak = 0; end
            default: begin m_lt = sat_inc(m_lt); m_streak = 0; end
        endcase
        m_state = kind;
    endfunction

    // Behavioural model advancing on each clock edge.
    always @(posedge clk) begin : mdl
        int n;
        if (rst_n) begin
            n = int'(gt) + int'(eq) + int'(lt);
            if (clr) begin
                model_clear();
            end else if (in_valid) begin
`ifdef CMP_MON_ONEHOT_CHECK_EN
                if (n == 1) model_take(eq ? 1 : (gt ? 2 : 3));
                else        m_err = 1;
`else
                if (n > 0)  model_take(eq ? 1 : (gt ? 2 : 3));
`endif
            end
        end
    end

    always @(negedge rst_n) model_clear();

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("gt_cnt", int'(gt_cnt), m_gt);
            chk("eq_cnt", int'(eq_cnt), m_eq);
            chk("lt_cnt", int'(lt_cnt), m_lt);
            chk("streak", int'(streak), m_streak);
            chk("state",  int'(state),  m_state);
            chk("lock",   int'(lock),   (m_streak >= int'(LOCK_N)) ? 1 : 0);
            chk("err",    int'(err),    m_err);
        end
    end

    task automatic step(input bit v, input bit g, input bit e, input bit l, input bit c);
        @(negedge clk);
        in_valid = v; gt = g; eq = e; lt = l; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit seq_eq [7] = '{1, 0, 1, 1, 1, 1, 0};
        bit seq_gt [7] = '{0, 1, 0, 0, 0, 0, 0};
        bit seq_lt [7] = '{0, 0, 0, 0, 0, 0, 1};
        int seq_lk [7] = '{0, 0, 0, 0, 0, 1, 0};

        // Reset, then idle cycles.
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_eq_cnt", int'(eq_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        repeat (5) step(0, 0, 0, 0, 0);
        chk("idle_state", int'(state), 0);
        chk("idle_gt_cnt", int'(gt_cnt), 0);
        chk("idle_eq_cnt", int'(eq_cnt), 0);
        chk("idle_lt_cnt", int'(lt_cnt), 0);
        chk("idle_streak", int'(streak), 0);
        chk("idle_lock", int'(lock), 0);
        chk("idle_err", int'(err), 0);

        // eq,gt,eq,eq,eq,eq,lt: lock only once four eq follow in a row.
        for (int i = 0; i < 7; i++) begin
            step(1, seq_gt[i], seq_eq[i], seq_lt[i], 0);
            chk($sformatf("seq_lock%0d", i), int'(lock), seq_lk[i]);
        end
        chk("seq_eq_cnt", int'(eq_cnt), 5);
        chk("seq_gt_cnt", int'(gt_cnt), 1);
        chk("seq_lt_cnt", int'(lt_cnt), 1);
        chk("seq_streak", int'(streak), 0);
        chk("seq_state", int'(state), 3);

        // Garbage flags with in_valid low must hold everything.
        step(0, 1, 1, 1, 0);
        chk("hold_state", int'(state), 3);

        // clr beats a simultaneous valid eq.
        step(0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 1, 0, 0);
        chk("pre_clr_eq_cnt", int'(eq_cnt), 3);
        step(1, 0, 1, 0, 1);
        chk("clr_eq_cnt", int'(eq_cnt), 0);
        chk("clr_streak", int'(streak), 0);
        chk("clr_state", int'(state), 0);
        chk("clr_lock", int'(lock), 0);

        // gt counter saturation.
        repeat (300) step(1, 1, 0, 0, 0);
        chk("sat_gt_cnt", int'(gt_cnt), 255);
        chk("sat_state", int'(state), 2);

        // Streak saturation keeps lock high; a gt drops both.
        step(0, 0, 0, 0, 1);
        repeat (260) step(1, 0, 1, 0, 0);
        chk("sat_streak", int'(streak), 255);
        chk("sat_eq_cnt", int'(eq_cnt), 255);
        chk("sat_lock", int'(lock), 1);
        step(1, 1, 0, 0, 0);
        chk("brk_streak", int'(streak), 0);
        chk("brk_lock", int'(lock), 0);

        // Malformed samples.
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0);
`ifdef CMP_MON_ONEHOT_CHECK_EN
        chk("mf_err", int'(err), 1);
        chk("mf_eq_cnt", int'(eq_cnt), 0);
        chk("mf_gt_cnt", int'(gt_cnt), 0);
        chk("mf_state", int'(state), 0);
`else
        chk("mf_err", int'(err), 0);
        chk("mf_eq_cnt", int'(eq_cnt), 1);
        chk("mf_gt_cnt", int'(gt_cnt), 0);
        chk("mf_state", int'(state), 1);
`endif
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0);
`ifdef CMP_MON_ONEHOT_CHECK_EN
        chk("mf2_gt_cnt", int'(gt_cnt), 0);
        chk("mf2_err", int'(err), 1);
`else
        chk("mf2_gt_cnt", int'(gt_cnt), 1);
        chk("mf2_state", int'(state), 2);
`endif
        step(0, 0, 0, 0, 1);
        chk("mf_clr_err", int'(err), 0);

        // Asynchronous reset mid-cycle during an eq streak of 3.
        repeat (3) step(1, 0, 1, 0, 0);
        chk("pre_rst_streak", int'(streak), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_streak", int'(streak), 0);
        chk("arst_eq_cnt", int'(eq_cnt), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_lock", int'(lock), 0);
        in_valid = 1'b0; eq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("post_rst_eq_cnt", int'(eq_cnt), 1);
        chk("post_rst_streak", int'(streak), 1);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
